// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words from UART RX bytes and
// writes them sequentially into instruction memory until the HALT word.
module program_loader #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              ADDR_WIDTH = 10,
    parameter int unsigned              IMEM_WORDS = 256,
    parameter logic [DATA_WIDTH-1:0]    HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_done,
    output logic                    o_imem_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_imem_addr,
    output logic [DATA_WIDTH-1:0]   o_imem_data,
    output logic                    o_cpu_stall,
    output logic                    o_load_done,
    output logic                    o_error,
    output logic [ADDR_WIDTH-2:0]   o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-2:0] WORD_LIMIT = (ADDR_WIDTH-1)'(IMEM_WORDS);

    state_t                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-2:0]   word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]   shifted;

    assign shifted = {asm_q[DATA_WIDTH-9:0], i_rx_data};

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    word_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (i_rx_done) begin
                    asm_d      = shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_cnt_q == WORD_LIMIT) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_WRITE;
                            data_d  = shifted;
                        end
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (data_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    // A byte arriving during the write cycle starts the next word.
                    if (i_rx_done) begin
                        asm_d      = shifted;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_imem_wr_en = (state_q == S_WRITE);
    assign o_imem_addr  = {word_cnt_q[ADDR_WIDTH-3:0], 2'b00};
    assign o_imem_data  = data_q;
    assign o_cpu_stall  = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign o_load_done  = (state_q == S_DONE);
    assign o_error      = (state_q == S_ERROR);
    assign o_word_count = word_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a byte-level reference model predicts
// every memory write; a negedge monitor checks writes as the DUT issues them.
module tb_program_loader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_start = 1'b0;
    logic [7:0]    i_rx_data = '0;
    logic          i_rx_done = 1'b0;
    logic          o_imem_wr_en;
    logic [AW-1:0] o_imem_addr;
    logic [DW-1:0] o_imem_data;
    logic          o_cpu_stall;
    logic          o_load_done;
    logic          o_error;
    logic [AW-2:0] o_word_count;

    program_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .IMEM_WORDS(NW),
        .HALT_WORD (HALT)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .o_imem_wr_en(o_imem_wr_en),
        .o_imem_addr (o_imem_addr),
        .o_imem_data (o_imem_data),
        .o_cpu_stall (o_cpu_stall),
        .o_load_done (o_load_done),
        .o_error     (o_error),
        .o_word_count(o_word_count)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic armed = 1'b0;

    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } wr_t;
    wr_t exp_q[$];

    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
    mode_t      mode = M_IDLE;
    logic [7:0] bytes[$];
    int         nwords = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must match the oldest predicted one.
    always @(negedge i_clock) begin
        if (armed && o_imem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %h data %h expected=no write", o_imem_addr, o_imem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(o_imem_addr), e.addr);
                check("wr_data", o_imem_data, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // One clock of stimulus; the model is updated with what the DUT will see.
    task automatic step(input logic s, input logic r, input logic [7:0] d);
        logic [31:0] w;
        i_start   = s;
        i_rx_done = r;
        i_rx_data = d;
        if (!i_reset) begin
            mode   = M_IDLE;
            nwords = 0;
            bytes.delete();
        end else begin
            if (r && mode == M_LOAD) begin
                bytes.push_back(d);
                if (bytes.size() == 4) begin
                    w = {bytes[0], bytes[1], bytes[2], bytes[3]};
                    bytes.delete();
                    if (nwords == NW) begin
                        mode = M_ERR;
                    end else begin
                        exp_q.push_back('{32'(nwords * 4), w, cyc + 1});
                        nwords++;
                        if (w == HALT) mode = M_DONE;
                    end
                end
            end
            if (s && mode != M_LOAD) begin
                mode   = M_LOAD;
                nwords = 0;
                bytes.delete();
            end
        end
        @(posedge i_clock);
        #1;
        i_start   = 1'b0;
        i_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input bit rnd_start);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, v[31:24]);
            v = v << 8;
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            if (rnd_start && mode == M_LOAD && $urandom_range(0, 7) == 0) step(1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_word_count"}, 32'(o_word_count), 32'(nwords));
        check({tag, "_addr"}, 32'(o_imem_addr), 32'(nwords * 4));
        check({tag, "_load_done"}, 32'(o_load_done), 32'(mode == M_DONE));
        check({tag, "_error"}, 32'(o_error), 32'(mode == M_ERR));
        check({tag, "_stall"}, 32'(o_cpu_stall), 32'(mode == M_LOAD));
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        @(posedge i_clock);
        #1;
        idle(2);
        armed = 1'b1;
        check("reset_data", o_imem_data, 32'h0);
        check("reset_wr_en", 32'(o_imem_wr_en), 32'h0);
        check_status("reset");
        i_reset = 1'b1;
        idle(1);

        // Directed program with exact stall/done timing around the HALT write.
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h20080005, 0, 1'b0);
        idle(1);
        send_word(32'h8C090004, 1, 1'b0);
        send_word(HALT, 0, 1'b0);
        check("halt_wr_en", 32'(o_imem_wr_en), 32'h1);
        check("halt_stall_in_write", 32'(o_cpu_stall), 32'h1);
        idle(1);
        check("halt_stall_after", 32'(o_cpu_stall), 32'h0);
        check_status("prog1");
        check("prog1_count3", 32'(o_word_count), 32'd3);

        // Back-to-back bytes: next word's first byte lands in the write cycle.
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h00000001, 0, 1'b0);
        send_word(32'h00000002, 0, 1'b0);
        send_word(HALT, 0, 1'b0);
        idle(2);
        check_status("b2b");

        // Overflow: five non-HALT words into a four-word memory.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(32'h11110000 + 32'(i), 0, 1'b0);
        idle(2);
        check_status("ovf");
        check("ovf_error", 32'(o_error), 32'h1);
        step(1'b1, 1'b0, 8'h00);
        send_word(HALT, 0, 1'b0);
        idle(2);
        check_status("ovf_restart");

        // Reset during LOAD after two bytes of word 1.
        step(1'b1, 1'b0, 8'h00);
        send_word(32'hA5A5A5A5, 0, 1'b0);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        i_reset = 1'b0;
        idle(1);
        check("rst_data", o_imem_data, 32'h0);
        check("rst_wr_en", 32'(o_imem_wr_en), 32'h0);
        check_status("rst");
        i_reset = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        send_word(32'hCAFEF00D, 1, 1'b0);
        send_word(HALT, 1, 1'b0);
        idle(2);
        check_status("rst_reload");

        // Start pulse after six bytes is ignored.
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h01020304, 0, 1'b0);
        step(1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 8'h06);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b1, 8'h08);
        send_word(HALT, 0, 1'b0);
        idle(2);
        check_status("midstart");

        // Bytes in DONE, then in IDLE, are ignored.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
        check_status("done_bytes");
        i_reset = 1'b0;
        idle(1);
        i_reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
        check_status("idle_bytes");

        // Randomized programs with gaps, stray start pulses and overflow cases.
        for (int it = 0; it < 25; it++) begin
            step(1'b1, 1'b0, 8'h00);
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
                send_word(w, 2, 1'b1);
            end
            if (mode == M_LOAD) send_word(HALT, 2, 1'b1);
            idle(2);
            check_status("rand");
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom));
                check_status("rand_ignore");
            end
        end

        idle(3);
        check("pending_writes", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction stream that the decode stage consumes.
- Receives a program as a byte stream from the UART receiver, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU stalled while loading; finishes on the HALT word.
- Sits between the UART RX and the instruction memory write port, under debug-unit control.

Parameters:
DATA_WIDTH, 32, instruction word width (fixed 4 bytes).
ADDR_WIDTH, 10, instruction memory byte-address width.
IMEM_WORDS, 256, capacity in words; IMEM_WORDS*4 <= 2**ADDR_WIDTH.
HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is itself written to memory.

Ports:
i_clock  in  1  clock; all logic on rising edge.
i_reset  in  1  synchronous, active-low reset.
i_start  in  1  one-cycle pulse; begins a load from address 0.
i_rx_data  in  8  received byte.
i_rx_done  in  1  one-cycle strobe; i_rx_data valid this cycle.
o_imem_wr_en  out  1  one-cycle instruction memory write strobe.
o_imem_addr  out  ADDR_WIDTH  byte address of write; word aligned.
o_imem_data  out  DATA_WIDTH  word to write.
o_cpu_stall  out  1  high while LOAD or WRITE.
o_load_done  out  1  high in DONE.
o_error  out  1  high in ERROR.
o_word_count  out  ADDR_WIDTH-1  words written in the current load, HALT included.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - State IDLE; o_imem_wr_en=0, o_imem_addr=0, o_imem_data=0, o_cpu_stall=0, o_load_done=0, o_error=0, o_word_count=0; byte counter 0; assembly register 0.
  - Reset mid-load discards the partial word. No write occurs in the reset cycle.
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - i_start goes to LOAD; clears word count, address and byte counter.
  - i_rx_done is ignored.
- LOAD:
  - Each i_rx_done shifts the byte in. The first byte of a word becomes bits 31:24, the fourth becomes bits 7:0. The byte counter increments mod 4.
  - On the 4th byte, the next cycle is WRITE with the assembled word latched into o_imem_data.
  - If o_word_count == IMEM_WORDS when the 4th byte arrives, go to ERROR instead. No write occurs.
- WRITE (exactly one cycle):
  - o_imem_wr_en=1, o_imem_addr = 4*o_word_count.
  - Next edge: o_word_count += 1 (o_imem_addr follows).
  - If the word equals HALT_WORD, go to DONE; otherwise go to LOAD.
  - An i_rx_done in the WRITE cycle is accepted as byte 0 of the next word. It is never dropped. If the word was HALT, that byte is discarded.
- Write latency: the 4th byte strobe at cycle N produces o_imem_wr_en=1 at cycle N+1.
- DONE:
  - o_load_done=1, o_cpu_stall=0; bytes are ignored.
  - i_start restarts a load (to LOAD, counters cleared).
- ERROR:
  - o_error=1, o_cpu_stall=0; bytes are ignored.
  - i_start restarts a load. The memory contents beyond the last write are undefined.
- i_start while in LOAD or WRITE is ignored; there is no restart mid-load.
- o_imem_wr_en is never high outside WRITE. At most one write per 4 accepted bytes.
- o_imem_data holds its last written value outside WRITE.
- Address never wraps: the word index tops at IMEM_WORDS, and the overflow path goes to ERROR.

Test Plan:
1. Reset high, pulse i_start, send bytes 20 08 00 05, 8C 09 00 04, FF FF FF FF:
   - Writes 0x20080005 @0, 0x8C090004 @4, 0xFFFFFFFF @8.
   - Each write strobe is 1 cycle after the 4th byte.
   - o_word_count=3, o_load_done=1, o_cpu_stall drops the cycle after the HALT write.
2. Back-to-back bytes, with the 5th i_rx_done in the WRITE cycle of word 0 (bytes 00 00 00 01, 00 00 00 02, HALT):
   - Second write is 0x00000002 @4; no byte lost.
3. IMEM_WORDS=4, send 5 non-HALT words:
   - Four writes @0,4,8,12; no fifth write; o_error=1, o_word_count=4.
   - i_start then restarts at @0.
4. Reset asserted after 2 bytes of word 1 (during LOAD):
   - All outputs reach reset values the next edge; no write is issued.
   - A new i_start plus a full program loads from @0 correctly.
5. i_start pulsed mid-load after 6 bytes:
   - Ignored; load continues and completes with the expected addresses and data.
6. In IDLE and DONE, 8 bytes are strobed:
   - o_imem_wr_en stays 0 and o_word_count is unchanged.
